// File: rtl/lr_pkg.sv
// Shared types and width helpers for the linear-regression training and prediction stages.
package lr_pkg;

    localparam int N_DEF = 32;

    typedef enum logic [2:0] {ACCUM, CALC, DIV1, DIV0, DONE} lr_state_e;

    function automatic int cnt_w(input int samples);
        return $clog2(samples + 1);
    endfunction

    function automatic int d_w(input int n, input int samples);
        return 2 * n + 2 * cnt_w(samples) + 2;
    endfunction

endpackage

// File: rtl/lr_seq_divider.sv
// Signed restoring divider: one quotient bit per cycle on magnitudes, sign applied at the end.
// LR_ROUND_EN selects round-to-nearest (ties away from zero) instead of truncation.
module lr_seq_divider #(
    parameter int W = 8
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                start,
    input  logic signed [W-1:0] dividend,
    input  logic signed [W-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic signed [W-1:0] quotient,
    output logic signed [W-1:0] remainder
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  acc, qsh, dmag, dvd_mag, dvs_mag, acc_nx, q_nx, q_fin;
    logic [W:0]    shifted, trial;
    logic [CW-1:0] cnt;
    logic          qneg, rneg;

    assign dvd_mag = dividend[W-1] ? W'(-dividend) : W'(dividend);
    assign dvs_mag = divisor[W-1]  ? W'(-divisor)  : W'(divisor);

    always_comb begin
        shifted = {acc, qsh[W-1]};
        trial   = shifted - {1'b0, dmag};
        if (!trial[W]) begin
            acc_nx = trial[W-1:0];
            q_nx   = {qsh[W-2:0], 1'b1};
        end else begin
            acc_nx = shifted[W-1:0];
            q_nx   = {qsh[W-2:0], 1'b0};
        end
        q_fin = q_nx;
`ifdef LR_ROUND_EN
        if ({acc_nx, 1'b0} >= {1'b0, dmag})
            q_fin = q_nx + W'(1);
`endif
    end

    // remainder always reflects the truncated quotient
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            acc       <= '0;
            qsh       <= '0;
            dmag      <= '0;
            cnt       <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc  <= '0;
                qsh  <= dvd_mag;
                dmag <= dvs_mag;
                qneg <= dividend[W-1] ^ divisor[W-1];
                rneg <= dividend[W-1];
                cnt  <= CW'(W);
                busy <= 1'b1;
            end else if (busy) begin
                acc <= acc_nx;
                qsh <= q_nx;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    quotient  <= qneg ? -$signed(q_fin) : $signed(q_fin);
                    remainder <= rneg ? -$signed(acc_nx) : $signed(acc_nx);
                end
            end
        end
    end

endmodule

// File: rtl/linear_regression_training.sv
// Batch least-squares trainer producing integer slope/intercept for the prediction stage.
// LR_ROUND_EN (in lr_seq_divider) switches both divisions to round-to-nearest.
module linear_regression_training
    import lr_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int SAMPLES = 16
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic signed [N-1:0] i_samples_x_in,
    input  logic signed [N-1:0] i_samples_y_in,
    input  logic                i_samples_vld,
    output logic                o_ready,
    output logic signed [N-1:0] o_theta0_out,
    output logic signed [N-1:0] o_theta1_out,
    output logic                o_theta1_out_vld,
    output logic                o_done,
    output logic                o_degenerate
);
    localparam int CNT_W = cnt_w(SAMPLES);
    localparam int D_W   = d_w(N, SAMPLES);
    localparam logic signed [D_W-1:0] SAMPLES_D = D_W'(SAMPLES);

    lr_state_e              state;
    logic [CNT_W-1:0]       cnt;
    logic signed [D_W-1:0]  sx, sy, sxy, sxx;
    logic signed [D_W-1:0]  x_ext, y_ext, xy_ext, xx_ext, num1, den1, t1_ext, num0;
    logic signed [2*N-1:0]  xy, xx;
    logic signed [N-1:0]    t1_q, div_q;
    logic                   degen_q, accept, last, setup0;
    logic                   div_start, div_done, div_busy_unused;
    logic signed [D_W-1:0]  div_dvd, div_dvs, div_quotient, div_rem_unused;
    logic [D_W-N-1:0]       div_q_hi_unused;

    assign xy     = i_samples_x_in * i_samples_y_in;
    assign xx     = i_samples_x_in * i_samples_x_in;
    assign x_ext  = {{(D_W-N){i_samples_x_in[N-1]}}, i_samples_x_in};
    assign y_ext  = {{(D_W-N){i_samples_y_in[N-1]}}, i_samples_y_in};
    assign xy_ext = {{(D_W-2*N){xy[2*N-1]}}, xy};
    assign xx_ext = {{(D_W-2*N){xx[2*N-1]}}, xx};

    assign num1 = SAMPLES_D * sxy - sx * sy;
    assign den1 = SAMPLES_D * sxx - sx * sx;

    assign {div_q_hi_unused, div_q} = div_quotient;
    // the second division is set up from the coefficient as it will be published
    assign t1_ext = degen_q ? '0 : {{(D_W-N){div_q[N-1]}}, div_q};
    assign num0   = sy - t1_ext * sx;

    assign accept = (state == ACCUM) && o_ready && i_samples_vld;
    assign last   = (cnt == CNT_W'(SAMPLES - 1));
    assign setup0 = (state == DIV1) && (degen_q || div_done);

    always_comb begin
        div_start = 1'b0;
        div_dvd   = num1;
        div_dvs   = den1;
        if (state == CALC) begin
            div_start = (den1 != '0);
        end else if (setup0) begin
            div_start = 1'b1;
            div_dvd   = num0;
            div_dvs   = SAMPLES_D;
        end
    end

    lr_seq_divider #(.W(D_W)) u_div (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .start     (div_start),
        .dividend  (div_dvd),
        .divisor   (div_dvs),
        .busy      (div_busy_unused),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_rem_unused)
    );

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state            <= ACCUM;
            cnt              <= '0;
            sx               <= '0;
            sy               <= '0;
            sxy              <= '0;
            sxx              <= '0;
            t1_q             <= '0;
            degen_q          <= 1'b0;
            o_ready          <= 1'b0;
            o_theta0_out     <= '0;
            o_theta1_out     <= '0;
            o_theta1_out_vld <= 1'b0;
            o_done           <= 1'b0;
            o_degenerate     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ACCUM: begin
                    o_ready <= !(accept && last);
                    if (accept) begin
                        sx  <= sx + x_ext;
                        sy  <= sy + y_ext;
                        sxy <= sxy + xy_ext;
                        sxx <= sxx + xx_ext;
                        cnt <= cnt + CNT_W'(1);
                        if (last)
                            state <= CALC;
                    end
                end
                CALC: begin
                    degen_q <= (den1 == '0);
                    state   <= DIV1;
                end
                DIV1: begin
                    if (setup0) begin
                        t1_q  <= t1_ext[N-1:0];
                        state <= DIV0;
                    end
                end
                DIV0: begin
                    if (div_done) begin
                        o_theta1_out     <= t1_q;
                        o_theta0_out     <= div_q;
                        o_theta1_out_vld <= 1'b1;
                        o_done           <= 1'b1;
                        o_degenerate     <= degen_q;
                        sx               <= '0;
                        sy               <= '0;
                        sxy              <= '0;
                        sxx              <= '0;
                        cnt              <= '0;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    o_ready <= 1'b1;
                    state   <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_linear_regression_training.sv
// Directed bench for linear_regression_training with SAMPLES=4 and hand-computed coefficients.
module tb_linear_regression_training;
    localparam int N       = 32;
    localparam int SAMPLES = 4;
    localparam int CNT_W   = $clog2(SAMPLES + 1);
    localparam int D_W     = 2 * N + 2 * CNT_W + 2;
    localparam int LAT     = 2 * D_W + 3;
    localparam int LAT_DEG = D_W + 3;
`ifdef LR_ROUND_EN
    localparam int T0_HALF = 1;
`else
    localparam int T0_HALF = 0;
`endif

    logic                i_clock = 1'b0;
    logic                i_reset = 1'b0;
    logic signed [N-1:0] x = '0, y = '0;
    logic                vld = 1'b0;
    logic                o_ready, o_theta1_out_vld, o_done, o_degenerate;
    logic signed [N-1:0] o_theta0_out, o_theta1_out;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;
    bit stable;

    linear_regression_training #(.N(N), .SAMPLES(SAMPLES)) dut (
        .i_clock          (i_clock),
        .i_reset          (i_reset),
        .i_samples_x_in   (x),
        .i_samples_y_in   (y),
        .i_samples_vld    (vld),
        .o_ready          (o_ready),
        .o_theta0_out     (o_theta0_out),
        .o_theta1_out     (o_theta1_out),
        .o_theta1_out_vld (o_theta1_out_vld),
        .o_done           (o_done),
        .o_degenerate     (o_degenerate)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic feed(input int xs[4], input int ys[4]);
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clock);
            x   = xs[i];
            y   = ys[i];
            vld = 1'b1;
            @(posedge i_clock);
        end
        #1 vld = 1'b0;
    endtask

    // Counts cycles from the last accepted sample to o_done; optionally spams
    // samples while busy and tracks whether the old 2/3 model stays published.
    task automatic wait_done(input bit junk, output int l, output bit st);
        l  = 0;
        st = 1'b1;
        while (l < 1000) begin
            @(posedge i_clock);
            #1 l++;
            if (o_done) break;
            if (!(o_theta1_out == 2 && o_theta0_out == 3 && o_theta1_out_vld)) st = 1'b0;
            x   = 77;
            y   = -9;
            vld = junk && (l < 100);
        end
        vld = 1'b0;
    endtask

    task automatic after_done(input string tag);
        @(posedge i_clock);
        #1;
        check({tag, "_done_pulse"}, o_done, 0);
        check({tag, "_ready"}, o_ready, 1);
    endtask

    initial begin
        repeat (3) @(posedge i_clock);
        #1;
        check("rst_theta0", o_theta0_out, 0);
        check("rst_theta1", o_theta1_out, 0);
        check("rst_vld", o_theta1_out_vld, 0);
        check("rst_done", o_done, 0);
        check("rst_degen", o_degenerate, 0);
        check("rst_ready", o_ready, 0);
        @(negedge i_clock) i_reset = 1'b1;
        @(posedge i_clock);
        #1 check("ready_after_rst", o_ready, 1);

        // y = 2x + 3
        feed('{0, 1, 2, 3}, '{3, 5, 7, 9});
        wait_done(1'b0, lat, stable);
        check("b1_latency", lat, LAT);
        check("b1_theta1", o_theta1_out, 2);
        check("b1_theta0", o_theta0_out, 3);
        check("b1_vld", o_theta1_out_vld, 1);
        check("b1_degen", o_degenerate, 0);
        after_done("b1");

        // retrain to y = -3x + 1 with junk samples offered while busy
        feed('{0, 1, 2, 3}, '{1, -2, -5, -8});
        wait_done(1'b1, lat, stable);
        check("b2_old_model_stable", stable, 1);
        check("b2_latency", lat, LAT);
        check("b2_theta1", o_theta1_out, -3);
        check("b2_theta0", o_theta0_out, 1);
        check("b2_vld", o_theta1_out_vld, 1);
        after_done("b2");

        // num1/den1 = 8/20, num0/den0 = 2/4
        feed('{0, 1, 2, 3}, '{0, 0, 1, 1});
        wait_done(1'b0, lat, stable);
        check("b3_theta1", o_theta1_out, 0);
        check("b3_theta0", o_theta0_out, T0_HALF);
        after_done("b3");

        // all x equal -> zero denominator
        feed('{5, 5, 5, 5}, '{2, 4, 6, 8});
        wait_done(1'b0, lat, stable);
        check("deg_latency", lat, LAT_DEG);
        check("deg_flag", o_degenerate, 1);
        check("deg_theta1", o_theta1_out, 0);
        check("deg_theta0", o_theta0_out, 5);
        after_done("deg");

        // asynchronous reset in the middle of the slope division
        feed('{0, 1, 2, 3}, '{3, 5, 7, 9});
        repeat (20) @(posedge i_clock);
        #2 i_reset = 1'b0;
        #1;
        check("mid_rst_theta0", o_theta0_out, 0);
        check("mid_rst_theta1", o_theta1_out, 0);
        check("mid_rst_vld", o_theta1_out_vld, 0);
        check("mid_rst_degen", o_degenerate, 0);
        check("mid_rst_ready", o_ready, 0);
        @(negedge i_clock) i_reset = 1'b1;
        @(posedge i_clock);
        #1 check("mid_rst_ready_up", o_ready, 1);
        feed('{0, 1, 2, 3}, '{1, -2, -5, -8});
        wait_done(1'b0, lat, stable);
        check("post_rst_latency", lat, LAT);
        check("post_rst_theta1", o_theta1_out, -3);
        check("post_rst_theta0", o_theta0_out, 1);
        check("post_rst_vld", o_theta1_out_vld, 1);
        check("post_rst_degen", o_degenerate, 0);
        after_done("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
